// File: rtl/keyboard_decoder.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_decoder
// Description : Turns a PS/2 Set 2 scan-code byte stream into movement
//               levels and a 16-bit keycode. It tracks the E0 (extended),
//               F0 (break) and E1 (Pause) prefixes and keeps one pressed bit
//               per movement key: W/S/A/D and the four arrows.
// Ports       : clk           - single clock (VGA pixel clock domain)
//               rst           - asynchronous active-high reset
//               rx_data       - received byte, qualified by rx_valid
//               rx_valid      - one-cycle strobe per received byte
//               keycode       - {prefix, code} of the most recent make
//               keycode_valid - one-cycle pulse when a make writes keycode
//               move_up/down/left/right - level while the matching key is held
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int PAUSE_SKIP     = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        move_up,
    output logic        move_down,
    output logic        move_left,
    output logic        move_right
);

    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_SK_W = $clog2(PAUSE_SKIP + 1);

    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_SK_W-1:0] c_SKIP_LOAD = c_SK_W'(PAUSE_SKIP);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_SKIP    = 3'd4;

    // Pressed-bit layout: [3:0] = W,S,A,D ; [7:4] = Up,Down,Left,Right arrows.
    logic [2:0]        r_state;
    logic [7:0]        r_pressed;
    logic [15:0]       r_keycode;
    logic              r_keycode_valid;
    logic [3:0]        r_move;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_SK_W-1:0] r_skip_cnt;

    logic [2:0]        w_state_nxt;
    logic [7:0]        w_pressed_nxt;
    logic [15:0]       w_keycode_nxt;
    logic              w_keycode_valid_nxt;
    logic [c_TO_W-1:0] w_to_cnt_nxt;
    logic [c_SK_W-1:0] w_skip_cnt_nxt;
    logic [7:0]        w_letter_mask;
    logic [7:0]        w_arrow_mask;

    // Which pressed bit a byte maps to, for plain and for E0-prefixed codes.
    always_comb begin
        w_letter_mask = 8'h00;
        w_arrow_mask  = 8'h00;
        case (rx_data)
            8'h1D:   w_letter_mask = 8'b0000_0001;
            8'h1B:   w_letter_mask = 8'b0000_0010;
            8'h1C:   w_letter_mask = 8'b0000_0100;
            8'h23:   w_letter_mask = 8'b0000_1000;
            default: w_letter_mask = 8'h00;
        endcase
        case (rx_data)
            8'h75:   w_arrow_mask = 8'b0001_0000;
            8'h72:   w_arrow_mask = 8'b0010_0000;
            8'h6B:   w_arrow_mask = 8'b0100_0000;
            8'h74:   w_arrow_mask = 8'b1000_0000;
            default: w_arrow_mask = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_pressed_nxt       = r_pressed;
        w_keycode_nxt       = r_keycode;
        w_keycode_valid_nxt = 1'b0;
        w_to_cnt_nxt        = r_to_cnt;
        w_skip_cnt_nxt      = r_skip_cnt;

        if (r_state == S_IDLE) begin
            w_to_cnt_nxt = '0;
            if (rx_valid) begin
                case (rx_data)
                    8'hE0: w_state_nxt = S_EXT;
                    8'hF0: w_state_nxt = S_BRK;
                    8'hE1: begin
                        w_state_nxt    = S_SKIP;
                        w_skip_cnt_nxt = c_SKIP_LOAD;
                    end
                    // Controller responses / errors, not key events.
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                    default: begin
                        w_keycode_nxt       = {8'h00, rx_data};
                        w_keycode_valid_nxt = 1'b1;
                        w_pressed_nxt       = r_pressed | w_letter_mask;
                    end
                endcase
            end
        end else if (rx_valid) begin
            w_to_cnt_nxt = '0;
            case (r_state)
                S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else begin
                        w_state_nxt = S_IDLE;
                        // E0 12 is the fake-shift filler around some keys.
                        if (rx_data != 8'h12) begin
                            w_keycode_nxt       = {8'hE0, rx_data};
                            w_keycode_valid_nxt = 1'b1;
                            w_pressed_nxt       = r_pressed | w_arrow_mask;
                        end
                    end
                end
                S_BRK: begin
                    w_state_nxt   = S_IDLE;
                    w_pressed_nxt = r_pressed & ~w_letter_mask;
                    if (r_keycode == {8'h00, rx_data}) begin
                        w_keycode_nxt = 16'h0000;
                    end
                end
                S_EXT_BRK: begin
                    w_state_nxt = S_IDLE;
                    if (rx_data != 8'h12) begin
                        w_pressed_nxt = r_pressed & ~w_arrow_mask;
                        if (r_keycode == {8'hE0, rx_data}) begin
                            w_keycode_nxt = 16'h0000;
                        end
                    end
                end
                default: begin
                    // S_SKIP: count off the rest of the Pause sequence.
                    if (r_skip_cnt <= c_SK_W'(1)) begin
                        w_state_nxt    = S_IDLE;
                        w_skip_cnt_nxt = '0;
                    end else begin
                        w_skip_cnt_nxt = r_skip_cnt - c_SK_W'(1);
                    end
                end
            endcase
        end else if (r_to_cnt == c_TO_LAST) begin
            // A lost byte must not leave the decoder stuck in a prefix state.
            w_state_nxt    = S_IDLE;
            w_to_cnt_nxt   = '0;
            w_skip_cnt_nxt = '0;
        end else begin
            w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_pressed       <= 8'h00;
            r_keycode       <= 16'h0000;
            r_keycode_valid <= 1'b0;
            r_move          <= 4'h0;
            r_to_cnt        <= '0;
            r_skip_cnt      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pressed       <= w_pressed_nxt;
            r_keycode       <= w_keycode_nxt;
            r_keycode_valid <= w_keycode_valid_nxt;
            // Each direction is the OR of its arrow and letter; no opposite-key masking.
            r_move          <= {w_pressed_nxt[0] | w_pressed_nxt[4],
                                w_pressed_nxt[1] | w_pressed_nxt[5],
                                w_pressed_nxt[2] | w_pressed_nxt[6],
                                w_pressed_nxt[3] | w_pressed_nxt[7]};
            r_to_cnt        <= w_to_cnt_nxt;
            r_skip_cnt      <= w_skip_cnt_nxt;
        end
    end

    assign keycode       = r_keycode;
    assign keycode_valid = r_keycode_valid;
    assign move_up       = r_move[3];
    assign move_down     = r_move[2];
    assign move_left     = r_move[1];
    assign move_right    = r_move[0];

endmodule
`default_nettype wire
